// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and defaults
package riscv_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT   = 64'h0000_0000_8000_0000;
  localparam int          FIFO_DEPTH_DEFAULT = 4;

  // Word handed to decode when a misaligned redirect target is reported (addi x0,x0,0)
  localparam logic [31:0] FAULT_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - imem request port and decode handshake bundle
// fetch_fault only exists when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_unit_if;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc, fetch_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc, fetch_fault,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
`else
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch queue with synchronous flush
module fetch_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [95:0]
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  entry_t                  push_data_i,
  input  logic                    pop_i,
  output entry_t                  pop_data_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Flush cancels any same-cycle push or pop; popping an empty queue is ignored
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero before the first push
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Upstream credit accounting must keep the queue from ever being pushed while full
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(do_push && (count_q == FULL)));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding decode
// Optional misaligned-redirect fault handling: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         redirect_i,
  input  logic [63:0]  redirect_pc_i,
  fetch_unit_if.master fetch_bus
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count;
  logic [63:0]   target_pc;
  logic          run, fault_present;
  logic          credit_ok, req, grant, rvalid, drop, push, valid, pop;
  fetch_entry_t  push_entry, head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  fetch_state_t state_q, state_d;

  assign target_pc = redirect_pc_i;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; FAULT presents its single entry only once all stale responses have drained
  always_comb begin
    state_d       = state_q;
    run           = 1'b0;
    fault_present = 1'b0;
    unique case (state_q)
      ST_RUN:   run = 1'b1;
      ST_FAULT: begin
        fault_present = !redirect_i && (discard_q == '0) && (outstanding_q == '0);
        if (fault_present && fetch_bus.instr_ready) begin
          state_d = ST_HALT;
        end
      end
      default:  ;
    endcase
    if (redirect_i) begin
      state_d = (redirect_pc_i[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
    end
  end

  assign fetch_bus.fetch_fault = fault_present;
`else
  // Without fault checking the low target bits are simply ignored
  assign target_pc     = redirect_pc_i & ~64'h3;
  assign run           = 1'b1;
  assign fault_present = 1'b0;
`endif

  // Request credit, response steering and decode handshake
  always_comb begin
    credit_ok  = ({1'b0, outstanding_q} + {1'b0, count}) < DEPTH_L;
    // Gated by reset so no request leaks out while the registers are being cleared
    req        = rst_ni && run && !redirect_i && credit_ok;
    grant      = req && fetch_bus.imem_gnt;
    rvalid     = fetch_bus.imem_rvalid;
    drop       = rvalid && (discard_q != '0);
    push       = rvalid && !drop && !redirect_i;
    valid      = (run && (count != '0) && !redirect_i) || fault_present;
    pop        = valid && fetch_bus.instr_ready;
    push_entry = '{pc: resp_pc_q, instr: fetch_bus.imem_rdata};
  end

  // Next-state for PCs and in-flight accounting; redirect overrides everything else
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rvalid);
    discard_d     = discard_q - CW'(drop);
    if (redirect_i) begin
      pc_d      = target_pc;
      resp_pc_d = target_pc;
      // outstanding_q already counts words still marked for discard, so every
      // response still in flight after this cycle is stale
      discard_d = outstanding_q - CW'(rvalid);
    end else begin
      if (grant) pc_d = pc_q + 64'd4;
      if (push)  resp_pc_d = resp_pc_q + 64'd4;
    end
  end

  // Fetch datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop && run),
    .pop_data_o  (head_entry),
    .count_o     (count)
  );

  assign fetch_bus.imem_req    = req;
  assign fetch_bus.imem_addr   = pc_q;
  assign fetch_bus.instr_valid = valid;
  assign fetch_bus.instr       = fault_present ? FAULT_NOP_INSTR : head_entry.instr;
  assign fetch_bus.pc          = fault_present ? pc_q : head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] TGT_A   = 64'h0000_0000_8000_0100;
  localparam logic [63:0] TGT_B   = 64'h0000_0000_8000_0300;
  localparam logic [63:0] TGT_C   = 64'h0000_0000_8000_0200;
  localparam logic [63:0] TGT_MIS = 64'h0000_0000_8000_0102;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        gnt_en, rsp_en;
  logic [63:0] inflight_q [$];
  int          total = 0;
  int          bad   = 0;
  int          waited;
  logic        found;

  fetch_unit_if fbus ();

  fetch_unit #(
    .RESET_PC   (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .fetch_bus     (fbus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory side for the current cycle: grant per gnt_en, oldest grant returned when rsp_en
  task automatic drive();
    fbus.imem_gnt = gnt_en;
    if (rsp_en && inflight_q.size() > 0) begin
      fbus.imem_rvalid = 1'b1;
      fbus.imem_rdata  = word_at(inflight_q[0]);
    end else begin
      fbus.imem_rvalid = 1'b0;
      fbus.imem_rdata  = 32'h0;
    end
    #1;
  endtask

  task automatic advance();
    if (fbus.imem_rvalid) void'(inflight_q.pop_front());
    if (fbus.imem_req && fbus.imem_gnt) inflight_q.push_back(fbus.imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = 64'h0;
    gnt_en           = 1'b1;
    rsp_en           = 1'b1;
    fbus.instr_ready = 1'b1;
    fbus.imem_gnt    = 1'b0;
    fbus.imem_rvalid = 1'b0;
    fbus.imem_rdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    drive();
    check_eq("rst_req",   64'(fbus.imem_req), 64'd0);
    check_eq("rst_valid", 64'(fbus.instr_valid), 64'd0);
    check_eq("rst_addr",  fbus.imem_addr, BASE);
    check_eq("rst_instr", 64'(fbus.instr), 64'd0);
    check_eq("rst_pc",    fbus.pc, 64'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("rst_fault", 64'(fbus.fetch_fault), 64'd0);
`endif
    advance();
    rst_n = 1'b1;

    // Back-to-back sequential fetch with single-cycle memory
    for (int i = 0; i < 8; i++) begin
      drive();
      check_eq("seq_req",   64'(fbus.imem_req), 64'd1);
      check_eq("seq_addr",  fbus.imem_addr, BASE + 64'(4 * i));
      check_eq("seq_valid", 64'(fbus.instr_valid), 64'(i >= 2));
      if (i >= 2) begin
        check_eq("seq_pc",    fbus.pc, BASE + 64'(4 * (i - 2)));
        check_eq("seq_instr", 64'(fbus.instr), 64'(word_at(BASE + 64'(4 * (i - 2)))));
      end
      advance();
    end

    // Decode stalls for 10 cycles: two more grants, then credit runs out
    fbus.instr_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      drive();
      check_eq("stall_req",  64'(fbus.imem_req), 64'(j < 2));
      check_eq("stall_head", fbus.pc, BASE + 64'd24);
      advance();
    end
    fbus.instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive();
      if (k == 0) check_eq("release_req_low", 64'(fbus.imem_req), 64'd0);
      if (k == 1) begin
        check_eq("release_req",  64'(fbus.imem_req), 64'd1);
        check_eq("release_addr", fbus.imem_addr, BASE + 64'd40);
      end
      check_eq("release_valid", 64'(fbus.instr_valid), 64'd1);
      check_eq("release_pc",    fbus.pc, BASE + 64'(4 * (6 + k)));
      check_eq("release_instr", 64'(fbus.instr), 64'(word_at(BASE + 64'(4 * (6 + k)))));
      advance();
    end

    // Hold responses so two are in flight, then redirect
    rsp_en = 1'b0;
    drive();
    check_eq("pre_redir_pc", fbus.pc, BASE + 64'd48);
    advance();
    redirect    = 1'b1;
    redirect_pc = TGT_A;
    drive();
    check_eq("redir_valid", 64'(fbus.instr_valid), 64'd0);
    check_eq("redir_req",   64'(fbus.imem_req), 64'd0);
    advance();
    redirect = 1'b0;
    rsp_en   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive();
      check_eq("after_redir_valid", 64'(fbus.instr_valid), 64'(c == 3));
      if (c == 0) begin
        check_eq("after_redir_req",  64'(fbus.imem_req), 64'd1);
        check_eq("after_redir_addr", fbus.imem_addr, TGT_A);
      end
      if (c == 1) check_eq("after_redir_addr2", fbus.imem_addr, TGT_A + 64'd4);
      if (c == 3) begin
        check_eq("after_redir_pc",    fbus.pc, TGT_A);
        check_eq("after_redir_instr", 64'(fbus.instr), 64'(word_at(TGT_A)));
      end
      advance();
    end

    // Redirect coinciding with a response and a ready decode stage
    redirect    = 1'b1;
    redirect_pc = TGT_B;
    drive();
    check_eq("same_cyc_rvalid", 64'(fbus.imem_rvalid), 64'd1);
    check_eq("same_cyc_valid",  64'(fbus.instr_valid), 64'd0);
    advance();
    redirect = 1'b0;
    for (int d = 0; d < 4; d++) begin
      drive();
      check_eq("same_cyc_after_valid", 64'(fbus.instr_valid), 64'(d >= 2));
      if (d == 0) check_eq("same_cyc_addr", fbus.imem_addr, TGT_B);
      if (d == 2) check_eq("same_cyc_pc0", fbus.pc, TGT_B);
      if (d == 3) check_eq("same_cyc_pc1", fbus.pc, TGT_B + 64'd4);
      advance();
    end

    // Grant withheld for three cycles
    for (int e = 0; e < 6; e++) begin
      gnt_en = (e >= 3);
      drive();
      if (e <= 3) begin
        check_eq("nogrant_req",  64'(fbus.imem_req), 64'd1);
        check_eq("nogrant_addr", fbus.imem_addr, TGT_B + 64'd16);
      end
      if (e == 4) check_eq("grant_addr_next", fbus.imem_addr, TGT_B + 64'd20);
      if (e == 0) check_eq("nogrant_pc0", fbus.pc, TGT_B + 64'd8);
      if (e == 1) check_eq("nogrant_pc1", fbus.pc, TGT_B + 64'd12);
      if (e >= 2 && e <= 4) check_eq("nogrant_empty", 64'(fbus.instr_valid), 64'd0);
      if (e == 5) begin
        check_eq("regrant_valid", 64'(fbus.instr_valid), 64'd1);
        check_eq("regrant_pc",    fbus.pc, TGT_B + 64'd16);
      end
      advance();
    end
    gnt_en = 1'b1;

    // Misaligned redirect target
    redirect    = 1'b1;
    redirect_pc = TGT_MIS;
    drive();
    check_eq("mis_redir_valid", 64'(fbus.instr_valid), 64'd0);
    advance();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 10) begin
      drive();
      if (fbus.instr_valid) begin
        found = 1'b1;
      end else begin
        check_eq("fault_wait_req", 64'(fbus.imem_req), 64'd0);
        advance();
        waited++;
      end
    end
    check_eq("fault_seen",  64'(found), 64'd1);
    check_eq("fault_req",   64'(fbus.imem_req), 64'd0);
    check_eq("fault_instr", 64'(fbus.instr), 64'h13);
    check_eq("fault_pc",    fbus.pc, TGT_MIS);
    check_eq("fault_flag",  64'(fbus.fetch_fault), 64'd1);
    advance();
    for (int h = 0; h < 3; h++) begin
      drive();
      check_eq("halt_req",   64'(fbus.imem_req), 64'd0);
      check_eq("halt_valid", 64'(fbus.instr_valid), 64'd0);
      advance();
    end
    redirect    = 1'b1;
    redirect_pc = TGT_C;
    drive();
    advance();
    redirect = 1'b0;
    drive();
    check_eq("resume_req",  64'(fbus.imem_req), 64'd1);
    check_eq("resume_addr", fbus.imem_addr, TGT_C);
    advance();
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 10) begin
      drive();
      if (fbus.instr_valid) found = 1'b1;
      else begin
        advance();
        waited++;
      end
    end
    check_eq("resume_seen",  64'(found), 64'd1);
    check_eq("resume_pc",    fbus.pc, TGT_C);
    check_eq("resume_fault", 64'(fbus.fetch_fault), 64'd0);
    advance();
`else
    drive();
    check_eq("aligned_req",  64'(fbus.imem_req), 64'd1);
    check_eq("aligned_addr", fbus.imem_addr, TGT_A);
    advance();
    waited = 0;
    found  = 1'b0;
    while (!found && waited < 10) begin
      drive();
      if (fbus.instr_valid) found = 1'b1;
      else begin
        advance();
        waited++;
      end
    end
    check_eq("aligned_seen", 64'(found), 64'd1);
    check_eq("aligned_pc",   fbus.pc, TGT_A);
    advance();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
